mem_subsys_ctrl: RTL and testbench

//   Memory subsystem (MSS) controller downstream of the tinyalu processor. Serves its byte-addressed

---
 rtl/tinyalu_pkg.sv | 8 +
 rtl/mem_subsys_ctrl_if.sv | 23 ++
 rtl/mss_sram.sv | 17 +
 rtl/mem_subsys_ctrl.sv | 99 +++++++++
 tb/tb_mem_subsys_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared state type, address width and counter sizing for the memory subsystem
package tinyalu_pkg;
    localparam int MSS_ADDR_W = 14;
    typedef enum logic [2:0] {IDLE, RD, WR_LO, WR_HI, WAIT, RESP} mss_state_t;
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction
endpackage

// File: rtl/mem_subsys_ctrl_if.sv
// mem_subsys_ctrl_if: processor-side request/response bus; mem_err exists only with MSS_ADDR_CHECK_EN
interface mem_subsys_ctrl_if #(parameter int ADDR_W = tinyalu_pkg::MSS_ADDR_W);
    logic              cs;
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addrout;
    logic [15:0]       datatomem;
    logic [7:0]        datafrommem;
    logic              mem_resp;
    logic              busy;
`ifdef MSS_ADDR_CHECK_EN
    logic              mem_err;
    modport master (output cs, read_req, write_req, addrout, datatomem,
                    input datafrommem, mem_resp, busy, mem_err);
    modport slave  (input cs, read_req, write_req, addrout, datatomem,
                    output datafrommem, mem_resp, busy, mem_err);
`else
    modport master (output cs, read_req, write_req, addrout, datatomem,
                    input datafrommem, mem_resp, busy);
    modport slave  (input cs, read_req, write_req, addrout, datatomem,
                    output datafrommem, mem_resp, busy);
`endif
endinterface

// File: rtl/mss_sram.sv
// mss_sram: byte-wide single-port synchronous RAM, one-cycle read latency, write-first
module mss_sram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [2**ADDR_W];
    // a write also returns the new byte on the read port
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= we_i ? wdata_i : mem_q[addr_i];
    end
endmodule

// File: rtl/mem_subsys_ctrl.sv
// mem_subsys_ctrl: byte-SRAM controller with wait states; MSS_ADDR_CHECK_EN adds wrap detection on mem_err
module mem_subsys_ctrl import tinyalu_pkg::*; #(
    parameter int ADDR_W      = MSS_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_subsys_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WAIT_CYCLES);
    mss_state_t        state_q, state_d;
    logic              req, accept, wrap;
    logic              req_seen_q, req_seen_d;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q, sram_addr;
    logic [15:0]       data_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        rdata, dout_q, sram_wdata;
    logic              resp_q, sram_we;

    assign req        = bus.cs && (bus.read_req || bus.write_req);
    assign accept     = state_q == IDLE && req && !req_seen_q;
    assign req_seen_d = req && (req_seen_q || accept);

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state: write wins over read, WAIT is skipped when there are no wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = accept ? (bus.write_req ? WR_LO : RD) : IDLE;
            RD, WR_HI: state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WR_LO:     state_d = WR_HI;
            WAIT:      state_d = (cnt_q == CW'(WAIT_CYCLES - 1)) ? RESP : WAIT;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // SRAM controls; in IDLE the live address is read so data is ready when RD ends
    always_comb begin
        sram_addr  = (state_q == IDLE) ? bus.addrout : ((state_q == WR_HI) ? addr_q + ADDR_W'(1) : addr_q);
        sram_we    = reset_n && (state_q == WR_LO || (state_q == WR_HI && !wrap));
        sram_wdata = (state_q == WR_HI) ? data_q[15:8] : data_q[7:0];
        bus.busy   = state_q != IDLE;
    end

    // one-shot request tracking, wait counter and registered responses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_seen_q <= 1'b0;
            cnt_q      <= '0;
            resp_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            req_seen_q <= req_seen_d;
            cnt_q      <= (state_q == WAIT) ? cnt_q + CW'(1) : '0;
            resp_q     <= state_q == RESP;
            if (state_d == RESP && !op_wr_q) dout_q <= rdata;
        end
    end

    // transaction capture on acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addrout;
            data_q  <= bus.datatomem;
            op_wr_q <= bus.write_req;
        end
    end

`ifdef MSS_ADDR_CHECK_EN
    logic err_q;
    assign wrap = op_wr_q && addr_q == '1;
    // error flag pulses alongside mem_resp for a write that would wrap
    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= state_q == RESP && wrap;
    end
    assign bus.mem_err = err_q;
`else
    assign wrap = 1'b0;
`endif

    assign bus.datafrommem = dout_q;
    assign bus.mem_resp    = resp_q;

    mss_sram #(.ADDR_W(ADDR_W)) u_sram (
        .clk     (clk),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_mem_subsys_ctrl.sv
// tb_mem_subsys_ctrl: two controllers (2 and 0 wait states) driven in lockstep against a byte-array model
module tb_mem_subsys_ctrl;
    import tinyalu_pkg::*;
    localparam int AW = MSS_ADDR_W;
    logic          clk = 1'b0, reset_n = 1'b0;
    logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0]   wdata = '0;
    int            checks = 0, errors = 0;
    logic [7:0]    mem_m [2**AW];
    bit            vld [2**AW];
    logic [7:0]    dexp = 8'h00;
    bit            dknown = 1'b1;

    always #5 clk = ~clk;

    mem_subsys_ctrl_if #(.ADDR_W(AW)) bus_a ();
    mem_subsys_ctrl_if #(.ADDR_W(AW)) bus_b ();
    assign bus_a.cs = cs;       assign bus_b.cs = cs;
    assign bus_a.read_req = rd; assign bus_b.read_req = rd;
    assign bus_a.write_req = wr; assign bus_b.write_req = wr;
    assign bus_a.addrout = addr; assign bus_b.addrout = addr;
    assign bus_a.datatomem = wdata; assign bus_b.datatomem = wdata;

    mem_subsys_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    mem_subsys_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one transaction on both controllers, then latency/pulse/data checks against the model
    task automatic xact(input bit w, input bit r, input logic [AW-1:0] a, input logic [15:0] d);
        int na = -1, nb = -1, ca = 0, cb = 0;
        logic ea = 1'b0, eb = 1'b0;
        bit wrp = 1'b0;
        logic [AW-1:0] a1;
        cs = 1'b1; wr = w; rd = r; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        chk("busy_a", bus_a.busy, 1);
        chk("busy_b", bus_b.busy, 1);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (bus_a.mem_resp) begin ca++; if (na < 0) na = e; end
            if (bus_b.mem_resp) begin cb++; if (nb < 0) nb = e; end
`ifdef MSS_ADDR_CHECK_EN
            if (bus_a.mem_resp) ea = bus_a.mem_err;
            if (bus_b.mem_resp) eb = bus_b.mem_err;
`endif
        end
        chk("lat_a", na, w ? 5 : 4);
        chk("lat_b", nb, w ? 3 : 2);
        chk("nresp_a", ca, 1);
        chk("nresp_b", cb, 1);
        chk("idle_a", bus_a.busy, 0);
        chk("idle_b", bus_b.busy, 0);
        if (w) begin
            a1 = a + AW'(1);
`ifdef MSS_ADDR_CHECK_EN
            wrp = a == '1;
`endif
            mem_m[a] = d[7:0]; vld[a] = 1'b1;
            if (!wrp) begin mem_m[a1] = d[15:8]; vld[a1] = 1'b1; end
        end else begin
            dknown = vld[a];
            dexp = mem_m[a];
        end
`ifdef MSS_ADDR_CHECK_EN
        chk("err_a", ea, wrp);
        chk("err_b", eb, wrp);
`endif
        if (dknown) begin
            chk("dout_a", bus_a.datafrommem, dexp);
            chk("dout_b", bus_b.datafrommem, dexp);
        end
    endtask

    initial begin
        int ca, cb;
        logic [AW-1:0] ra;
        int op;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_a", bus_a.mem_resp, 0);
        chk("rst_busy_a", bus_a.busy, 0);
        chk("rst_dout_a", bus_a.datafrommem, 0);
        chk("rst_dout_b", bus_b.datafrommem, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        // little-endian write, byte reads
        xact(1, 0, 14'h0010, 16'hBEEF);
        xact(0, 1, 14'h0010, 16'h0);
        chk("t1_lo", bus_a.datafrommem, 8'hEF);
        xact(0, 1, 14'h0011, 16'h0);
        chk("t1_hi", bus_b.datafrommem, 8'hBE);
        // held read yields one response until dropped
        ca = 0; cb = 0;
        cs = 1'b1; rd = 1'b1; addr = 14'h0010;
        repeat (20) begin
            @(posedge clk); #1;
            ca += int'(bus_a.mem_resp); cb += int'(bus_b.mem_resp);
        end
        cs = 1'b0; rd = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            ca += int'(bus_a.mem_resp); cb += int'(bus_b.mem_resp);
        end
        chk("held_a", ca, 1);
        chk("held_b", cb, 1);
        dexp = 8'hEF; dknown = 1'b1;
        chk("held_dout", bus_a.datafrommem, 8'hEF);
        xact(0, 1, 14'h0010, 16'h0);
        // simultaneous read and write is a write
        xact(1, 1, 14'h0020, 16'h1234);
        xact(0, 1, 14'h0020, 16'h0);
        chk("t4", bus_a.datafrommem, 8'h34);
        // wrap at top of memory
        xact(1, 0, 14'h0000, 16'h7766);
        xact(1, 0, 14'h3FFF, 16'hA55A);
        xact(0, 1, 14'h3FFF, 16'h0);
        chk("t5_top", bus_a.datafrommem, 8'h5A);
        xact(0, 1, 14'h0000, 16'h0);
`ifdef MSS_ADDR_CHECK_EN
        chk("t5_zero", bus_b.datafrommem, 8'h66);
`else
        chk("t5_zero", bus_b.datafrommem, 8'hA5);
`endif
        // reset during WR_HI keeps only the low byte
        xact(1, 0, 14'h0040, 16'h1111);
        cs = 1'b1; wr = 1'b1; addr = 14'h0040; wdata = 16'hCAFE;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy_a", bus_a.busy, 0);
        chk("t6_busy_b", bus_b.busy, 0);
        reset_n = 1'b1;
        ca = int'(bus_a.mem_resp); cb = int'(bus_b.mem_resp);
        repeat (8) begin
            @(posedge clk); #1;
            ca += int'(bus_a.mem_resp); cb += int'(bus_b.mem_resp);
        end
        chk("t6_noresp_a", ca, 0);
        chk("t6_noresp_b", cb, 0);
        mem_m[14'h0040] = 8'hFE;
        dexp = 8'h00; dknown = 1'b1;
        chk("t6_dout_rst", bus_a.datafrommem, 8'h00);
        xact(0, 1, 14'h0040, 16'h0);
        chk("t6_lo", bus_a.datafrommem, 8'hFE);
        xact(0, 1, 14'h0041, 16'h0);
        chk("t6_hi", bus_b.datafrommem, 8'h11);
        // random traffic in a small window so reads hit earlier writes
        for (int i = 0; i < 30; i++) begin
            ra = 14'h0100 + AW'($urandom_range(0, 7));
            op = int'($urandom_range(0, 2));
            xact(op != 0, op != 1, ra, 16'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
